// File: rtl/layer_sequencer.sv
// layer_sequencer: tiles one layer into (n,k) steps for the weight, input-feature
// and accumulator controllers, handshaking with each between steps.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_k, num_n      layer request and tile counts (sampled in IDLE only)
//   abort                    terminate the layer, back to IDLE with indices cleared
//   w_ready, if_done,
//   acc_drained              completion handshakes from the controllers
//   w_start, if_start,
//   acc_clr, acc_flush       one-cycle command pulses
//   k_idx, n_idx             current reduction / output tile indices
//   busy, done               activity flag and normal-completion pulse
module layer_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_k,
    input  logic [7:0] num_n,
    input  logic       abort,
    input  logic       w_ready,
    input  logic       if_done,
    input  logic       acc_drained,
    output logic       w_start,
    output logic       if_start,
    output logic       acc_clr,
    output logic       acc_flush,
    output logic [7:0] k_idx,
    output logic [7:0] n_idx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        STREAM,
        WAIT_IF,
        FLUSH,
        WAIT_DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_k_q;
    logic [CNT_W-1:0] num_n_q;
    logic [CNT_W-1:0] k_last;
    logic [CNT_W-1:0] n_last;

    // Last valid index of each loop; counts are never zero when these are used.
    assign k_last = num_k_q - CNT_W'(1);
    assign n_last = num_n_q - CNT_W'(1);

    // Every output is a flop written alongside the state it belongs to, so the
    // pulses are high exactly for the cycle the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            num_k_q   <= '0;
            num_n_q   <= '0;
            k_idx     <= '0;
            n_idx     <= '0;
            w_start   <= 1'b0;
            if_start  <= 1'b0;
            acc_clr   <= 1'b0;
            acc_flush <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            w_start   <= 1'b0;
            if_start  <= 1'b0;
            acc_clr   <= 1'b0;
            acc_flush <= 1'b0;
            done      <= 1'b0;

            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                k_idx <= '0;
                n_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if ((num_k != '0) && (num_n != '0)) begin
                                num_k_q <= num_k;
                                num_n_q <= num_n;
                                k_idx   <= '0;
                                n_idx   <= '0;
                                w_start <= 1'b1;
                                acc_clr <= 1'b1;
                                state   <= LOAD_W;
                            end else begin
                                // Empty layer: report completion without touching the datapath.
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    LOAD_W: state <= WAIT_W;
                    WAIT_W: begin
                        if (w_ready) begin
                            if_start <= 1'b1;
                            state    <= STREAM;
                        end
                    end
                    STREAM: state <= WAIT_IF;
                    WAIT_IF: begin
                        if (if_done) begin
                            if (k_idx == k_last) begin
                                acc_flush <= 1'b1;
                                state     <= FLUSH;
                            end else begin
                                k_idx   <= k_idx + CNT_W'(1);
                                w_start <= 1'b1;
                                state   <= LOAD_W;
                            end
                        end
                    end
                    FLUSH: state <= WAIT_DRAIN;
                    WAIT_DRAIN: begin
                        if (acc_drained) begin
                            if (n_idx == n_last) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                n_idx   <= n_idx + CNT_W'(1);
                                k_idx   <= '0;
                                w_start <= 1'b1;
                                acc_clr <= 1'b1;
                                state   <= LOAD_W;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to run one layer; sampled only in IDLE.
REQ-004 SHALL have port num_k  input  8  reduction (input-channel) tile count; latched when start is accepted.
REQ-005 SHALL have port num_n  input  8  output-column tile count; latched when start is accepted.
REQ-006 SHALL have port abort  input  1  terminates the layer; highest priority after rst.
REQ-007 SHALL have port w_ready  input  1  weight controller reports weight tile loaded and switched in.
REQ-008 SHALL have port if_done  input  1  input-feature controller reports tile stream complete.
REQ-009 SHALL have port acc_drained  input  1  accumulator bank written back.
REQ-010 SHALL have port w_start  output  1  one-cycle pulse: load weight tile (n_idx,k_idx).
REQ-011 SHALL have port if_start  output  1  one-cycle pulse: stream input-feature tile k_idx.
REQ-012 SHALL have port acc_clr  output  1  one-cycle pulse: clear accumulators before first k tile.
REQ-013 SHALL have port acc_flush  output  1  one-cycle pulse: write back accumulators.
REQ-014 SHALL have port k_idx  output  8  current reduction tile index.
REQ-015 SHALL have port n_idx  output  8  current output tile index.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at normal layer completion.

Function
REQ-018 SHALL implement states IDLE, LOAD_W, WAIT_W, STREAM, WAIT_IF, FLUSH, WAIT_DRAIN, DONE.
REQ-019 SHALL decode all outputs from registered state/counters only (Moore); no input-to-output combinational path.
REQ-020 IDLE: start=1 with num_k!=0 and num_n!=0 -> latch counts, k_idx=n_idx=0, go LOAD_W.
REQ-021 IDLE: start=1 with num_k==0 or num_n==0 -> go DONE directly; no w_start/if_start/acc pulses.
REQ-022 LOAD_W (one cycle): w_start=1; acc_clr=1 iff k_idx==0; -> WAIT_W.
REQ-023 WAIT_W: hold until w_ready=1, then -> STREAM.
REQ-024 STREAM (one cycle): if_start=1; -> WAIT_IF.
REQ-025 WAIT_IF: on if_done=1, if k_idx==num_k-1 -> FLUSH, else k_idx+1 and -> LOAD_W.
REQ-026 FLUSH (one cycle): acc_flush=1; -> WAIT_DRAIN.
REQ-027 WAIT_DRAIN: on acc_drained=1, if n_idx==num_n-1 -> DONE, else n_idx+1, k_idx=0, -> LOAD_W.
REQ-028 DONE (one cycle): done=1, busy=1; -> IDLE; k_idx/n_idx hold final values until next accepted start.
REQ-029 Latency: start sampled at edge t -> w_start high in cycle t+1; w_ready at edge t -> if_start in cycle t+1.
REQ-030 Indices compared against latched counts minus one in 8-bit arithmetic; num_k=255 and num_n=255 SHALL run 255x255 tiles with no wrap.
REQ-031 Changes to num_k/num_n/start while busy SHALL be ignored.
REQ-032 w_ready, if_done, acc_drained SHALL be ignored in any state other than the one that waits on them.
REQ-033 abort=1 in any non-IDLE state -> IDLE next edge, no done pulse, indices cleared to 0; abort in IDLE has no effect.
REQ-034 abort and a wait-state completion in the same cycle -> abort wins.
REQ-035 Per output tile, pulse order SHALL be acc_clr+w_start, if_start, {w_start, if_start} x (num_k-1), acc_flush.

Reset
REQ-036 rst=1 at an edge -> IDLE; all pulse outputs, busy, done =0; k_idx=n_idx=0; latched counts=0.
REQ-037 rst SHALL override start and abort and take effect from any state, including mid-layer.

Verification
REQ-038 num_k=1,num_n=1, start; w_ready 3 cycles after w_start, if_done 4 cycles after if_start, acc_drained 2 cycles after flush -> exactly one each of acc_clr, w_start, if_start, acc_flush, done; done 1 cycle after acc_drained sampled.
REQ-039 num_k=3,num_n=2, handshakes after 1 cycle -> 6 w_start, 6 if_start, 2 acc_clr, 2 acc_flush, 1 done; (n_idx,k_idx) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
REQ-040 num_k=0,num_n=4, start -> busy for 1 cycle (DONE), done pulse, no other pulses.
REQ-041 abort asserted in WAIT_IF with if_done=1 same cycle at (n,k)=(1,1) -> IDLE next cycle, no further pulses, no done, k_idx=n_idx=0.
REQ-042 rst asserted in WAIT_DRAIN mid-layer -> all outputs reset values next cycle; new start with num_k=2,num_n=1 completes normally.
REQ-043 spurious w_ready/if_done/acc_drained pulses in IDLE and in the wrong wait state, plus start while busy -> no state change, no extra pulses.
